// File: rtl/gate_truth_checker.sv
// Stimulus/response checker for a combinational gate: sweeps every input vector,
// samples the gate output after a settle interval and scores it against a truth table.
module gate_truth_checker #(
  parameter int unsigned          N_IN   = 1,
  parameter logic [2**N_IN-1:0]   TT     = 2'b01,
  parameter int unsigned          SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  output logic [N_IN-1:0] dut_a_o,
  input  logic            dut_y_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_count_o,
  output logic [N_IN-1:0] first_fail_vec_o,
  output logic            first_fail_valid_o
);

  localparam int unsigned SettleW = $clog2(SETTLE + 1);
  localparam int unsigned CntW    = N_IN + 1;

  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);
  localparam logic [N_IN-1:0]    VecLast    = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [N_IN-1:0]     dut_a_q, dut_a_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CntW-1:0]     err_count_q, err_count_d;
  logic [N_IN-1:0]     ff_vec_q, ff_vec_d;
  logic                ff_valid_q, ff_valid_d;

  logic mismatch;
  assign mismatch = (dut_y_i != TT[vec_q]);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    dut_a_d     = dut_a_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    ff_vec_d    = ff_vec_q;
    ff_valid_d  = ff_valid_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          vec_d       = '0;
          dut_a_d     = '0;
          err_count_d = '0;
          ff_valid_d  = 1'b0;
          pass_d      = 1'b0;
          settle_d    = '0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        settle_d = settle_q + SettleW'(1);
        if (settle_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_count_d = err_count_q + CntW'(1);
          if (!ff_valid_q) begin
            ff_vec_d   = vec_q;
            ff_valid_d = 1'b1;
          end
        end
        if (vec_q == VecLast) begin
          state_d = StDone;
        end else begin
          vec_d    = vec_q + N_IN'(1);
          dut_a_d  = vec_q + N_IN'(1);
          settle_d = '0;
          state_d  = StSettle;
        end
      end
      StDone: begin
        // err_count_q already includes any mismatch from the final sample.
        pass_d  = (err_count_q == '0);
        dut_a_d = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides every transition, including a pending sample; partial results survive.
    if (abort_i && (state_q != StIdle)) begin
      state_d     = StIdle;
      dut_a_d     = '0;
      pass_d      = 1'b0;
      vec_d       = vec_q;
      settle_d    = settle_q;
      err_count_d = err_count_q;
      ff_vec_d    = ff_vec_q;
      ff_valid_d  = ff_valid_q;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      settle_q    <= '0;
      dut_a_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      ff_vec_q    <= '0;
      ff_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      dut_a_q     <= dut_a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      ff_vec_q    <= ff_vec_d;
      ff_valid_q  <= ff_valid_d;
    end
  end

  assign dut_a_o            = dut_a_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign err_count_o        = err_count_q;
  assign first_fail_vec_o   = ff_vec_q;
  assign first_fail_valid_o = ff_valid_q;

endmodule
